// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, addresses a combinational IMEM and
// buffers {next-PC, instruction} pairs in a DEPTH-entry ready/valid queue toward decode.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IW       = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic                     CNTEN,
  output logic [XLEN-1:0]          ADDR_OUT_ROM,
  input  logic [IW-1:0]            Inst,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [IW-1:0]            id_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [IW-1:0]   inst;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [XLEN-1:0]   pc_q;
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              push_c;
  logic              pop_c;
  logic [XLEN-1:0]   pc_inc_c;
  entry_t            head_c;

  assign pc_inc_c = pc_q + XLEN'(PC_STEP);
  assign id_valid = (count_q != '0);
  assign pop_c    = id_valid & id_ready & ~redirect;
  // A pop in the same cycle frees the slot, so a full queue still accepts a fetch.
  assign push_c   = CNTEN & ~redirect & ((count_q < CNT_W'(DEPTH)) | pop_c);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      pc_q    <= redirect_pc;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) begin
        pc_q   <= pc_inc_c;
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem[wptr_q].npc  <= pc_inc_c;
      mem[wptr_q].inst <= Inst;
    end
  end

  assign head_c       = mem[rptr_q];
  assign id_pc        = id_valid ? head_c.npc  : '0;
  assign id_inst      = id_valid ? head_c.inst : '0;
  assign ADDR_OUT_ROM = pc_q;
  assign count        = count_q;

endmodule
